// File: rtl/mac_match_ctrl_if.sv
// Bundle between the frame sequencer, the host and the pattern comparator.
// Master is the host/comparator side; slave is the sequencer.
interface mac_match_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             data_valid;
    logic             sof;
    logic             eof;
    logic [31:0]      data_in;
    logic             cfg_wr;
    logic [31:0]      cfg_wdata;
    logic             cmp_match;
    logic             cmp_clear;
    logic [31:0]      cmp_pattern;
    logic [31:0]      cmp_data;
    logic             result_valid;
    logic             result_ready;
    logic             result_match;
    logic             result_err;
    logic             busy;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output data_valid, sof, eof, data_in,
        output cfg_wr, cfg_wdata, cmp_match, result_ready,
        input  cmp_clear, cmp_pattern, cmp_data,
        input  result_valid, result_match, result_err,
        input  busy, drop_count
    );

    modport slave (
        input  data_valid, sof, eof, data_in,
        input  cfg_wr, cfg_wdata, cmp_match, result_ready,
        output cmp_clear, cmp_pattern, cmp_data,
        output result_valid, result_match, result_err,
        output busy, drop_count
    );
endinterface

// File: rtl/mac_match_ctrl.sv
// Frame-level sequencer for the 32-bit MAC/IP pattern comparator:
// clears/loads it per frame, feeds a word window, reports one result.
module mac_match_ctrl #(
    parameter int WIN_START = 2,
    parameter int WIN_LEN   = 4,
    parameter int DRAIN_CYC = 5,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic n_rst,
    mac_match_ctrl_if.slave bus
);
    localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] L_WS  = CNT_W'(WIN_START);
    localparam logic [CNT_W-1:0] L_WE  = CNT_W'(WIN_START + WIN_LEN);
    localparam logic [CNT_W-1:0] L_MAX = '1;
    localparam logic [DW-1:0]    L_DRN = DW'(DRAIN_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t           r_state;
    logic [31:0]      r_shadow;
    logic [31:0]      r_pat;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_drop;
    logic [DW-1:0]    r_drain;
    logic             r_err;
    logic             r_skip;
    logic             r_rvalid;
    logic             r_rmatch;
    logic             r_rerr;

    logic             w_sof;
    logic             w_eof;
    logic             w_start;
    logic             w_hold;
    logic             w_in_win;
    logic             w_feed;
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_sof     = bus.data_valid & bus.sof;
    assign w_eof     = bus.data_valid & bus.eof;
    assign w_start   = (r_state == S_IDLE) & w_sof;
    assign w_hold    = (r_state == S_DRAIN) | (r_state == S_REPORT);
    assign w_idx     = (r_state == S_IDLE) ? '0 : r_cnt;
    assign w_in_win  = (w_idx >= L_WS) & (w_idx < L_WE);
    assign w_feed    = bus.data_valid & w_in_win &
                       (w_start | (r_state == S_ACTIVE));
    assign w_cnt_inc = (r_cnt == L_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_pat    <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_drop   <= '0;
            r_drain  <= '0;
            r_err    <= 1'b0;
            r_skip   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rmatch <= 1'b0;
            r_rerr   <= 1'b0;
        end else begin
            if (bus.cfg_wr)
                r_shadow <= bus.cfg_wdata;
            r_data <= w_feed ? bus.data_in : '0;

            // A dropped frame counts once; stray sofs inside it do not.
            if (w_start)
                r_skip <= 1'b0;
            else if (w_hold & w_sof)
                r_skip <= ~bus.eof;
            else if (w_eof)
                r_skip <= 1'b0;
            if (w_hold & w_sof & ~r_skip & (r_drop != L_MAX))
                r_drop <= r_drop + 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pat <= bus.cfg_wr ? bus.cfg_wdata : r_shadow;
                        r_cnt <= CNT_W'(1);
                        r_err <= 1'b0;
                        if (bus.eof) begin
                            r_state <= S_DRAIN;
                            r_drain <= L_DRN;
                        end else begin
                            r_state <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!bus.data_valid) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (bus.sof)
                            r_err <= 1'b1;
                        if (bus.eof) begin
                            r_state <= S_DRAIN;
                            r_drain <= L_DRN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain <= DW'(1)) begin
                        r_state  <= S_REPORT;
                        r_rvalid <= 1'b1;
                        r_rmatch <= bus.cmp_match & ~r_err &
                                    (r_pat != '0);
                        r_rerr   <= r_err;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                S_REPORT: begin
                    if (bus.result_ready) begin
                        r_state  <= S_IDLE;
                        r_rvalid <= 1'b0;
                        r_rmatch <= 1'b0;
                        r_rerr   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmp_clear    = w_start;
    assign bus.cmp_pattern  = r_pat;
    assign bus.cmp_data     = r_data;
    assign bus.result_valid = r_rvalid;
    assign bus.result_match = r_rmatch;
    assign bus.result_err   = r_rerr;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.drop_count   = r_drop;
endmodule

// File: tb/tb_mac_match_ctrl.sv
// Bench for mac_match_ctrl: vector table, corner sequences, random
// frames against a byte-stream search model and a comparator stand-in.
module tb_mac_match_ctrl;
    localparam int WS = 2;
    localparam int WL = 4;
    localparam int DC = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    mac_match_ctrl_if #(.CNT_W(CW)) bus ();

    mac_match_ctrl #(
        .WIN_START(WS),
        .WIN_LEN(WL),
        .DRAIN_CYC(DC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    // Comparator stand-in: 3 buffers then a sticky match register.
    logic [31:0] b0, b1, b2;
    logic        cm;

    function automatic logic hit(input logic [63:0] s,
                                 input logic [31:0] p);
        for (int k = 0; k < 5; k++)
            if (s[63-8*k -: 32] == p) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            b0 <= '0; b1 <= '0; b2 <= '0; cm <= 1'b0;
        end else begin
            b0 <= bus.cmp_data;
            b1 <= b0;
            b2 <= b1;
            if (bus.cmp_clear) cm <= 1'b0;
            else if (hit({b2, b1}, bus.cmp_pattern)) cm <= 1'b1;
        end
    end
    assign bus.cmp_match = cm;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot = 0;
    logic [31:0] fw [16];
    int fn = 6;
    int xsof = -1;

    typedef struct {
        string       nm;
        logic [31:0] pat;
        logic [31:0] w [6];
        int          bub;
        logic        em;
        logic        ee;
    } vec_t;

    vec_t vt [9];

    function automatic vec_t mk(input string nm, input logic [31:0] p,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] c, input logic [31:0] d,
        input logic [31:0] e, input logic [31:0] f,
        input int bub, input logic em, input logic ee);
        vec_t v;
        v.nm = nm; v.pat = p; v.bub = bub; v.em = em; v.ee = ee;
        v.w[0] = a; v.w[1] = b; v.w[2] = c;
        v.w[3] = d; v.w[4] = e; v.w[5] = f;
        return v;
    endfunction

    // Expected result from the frame as a byte stream: only window
    // words are visible, surrounded by zeros.
    function automatic logic [1:0] model(input logic [31:0] pat,
                                         input int n, input int bub);
        logic [7:0] q [$];
        logic found = 1'b0;
        logic err = (bub >= 0);
        repeat (4) q.push_back(8'h00);
        for (int i = WS; i < WS + WL && i < n; i++)
            for (int j = 3; j >= 0; j--)
                q.push_back(fw[i][8*j +: 8]);
        repeat (4) q.push_back(8'h00);
        for (int k = 0; k + 3 < q.size(); k++)
            if ({q[k], q[k+1], q[k+2], q[k+3]} == pat) found = 1'b1;
        return {(pat != 0) && !err && found, err};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.data_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
        bus.data_in = '0; bus.cfg_wr = 1'b0; bus.cfg_wdata = '0;
    endtask

    task automatic cfg(input logic [31:0] v);
        bus.cfg_wr = 1'b1; bus.cfg_wdata = v;
        tick;
        bus.cfg_wr = 1'b0;
    endtask

    task automatic send_frame(input int bub, input int cfg_at,
        input logic [31:0] cfg_val, input logic exp_clr,
        output int t0);
        t0 = cyc;
        for (int i = 0; i < fn; i++) begin
            if (i == bub) begin
                bus.data_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
                bus.cfg_wr = 1'b0;
                tick;
            end
            bus.data_valid = 1'b1;
            bus.sof = (i == 0) || (i == xsof);
            bus.eof = (i == fn - 1);
            bus.data_in = fw[i];
            bus.cfg_wr = (i == cfg_at);
            bus.cfg_wdata = cfg_val;
            if (i == 0) begin
                t0 = cyc;
                #1 check("cmp_clear_sof", bus.cmp_clear, exp_clr);
            end else if (i == 1) begin
                #1 check("cmp_clear_mid", bus.cmp_clear, 0);
            end
            tick;
        end
        idle_inputs();
    endtask

    task automatic wait_result(input string nm, input int t0,
                               output int lat);
        int k = 0;
        while (bus.result_valid !== 1'b1 && k < 60) begin
            tick;
            k++;
        end
        check({nm, "_rv"}, bus.result_valid, 1);
        lat = cyc - t0;
    endtask

    task automatic take_result;
        bus.result_ready = 1'b1;
        tick;
        bus.result_ready = 1'b0;
        check("rv_after_take", bus.result_valid, 0);
        check("busy_after_take", bus.busy, 0);
    endtask

    task automatic run_frame(input string nm, input logic [31:0] pat,
        input int bub, input int same_cyc, input logic [1:0] exp);
        int t0, lat;
        if (same_cyc == 0) cfg(pat);
        else cfg(~pat);
        send_frame(bub, same_cyc ? 0 : -1, pat, 1'b1, t0);
        check({nm, "_busy"}, bus.busy, 1);
        wait_result(nm, t0, lat);
        check({nm, "_lat"}, lat, fn + (bub >= 0 ? 1 : 0) + DC);
        check({nm, "_match"}, bus.result_match, exp[1]);
        check({nm, "_err"}, bus.result_err, exp[0]);
        take_result();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int t0, lat, n, bub, mode, p;
        logic [31:0] pat;
        logic seen;

        idle_inputs();
        bus.result_ready = 1'b0;
        repeat (3) tick;
        check("rst_busy", bus.busy, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_match", bus.result_match, 0);
        check("rst_err", bus.result_err, 0);
        check("rst_drop", bus.drop_count, 0);
        check("rst_cdata", bus.cmp_data, 0);
        check("rst_cpat", bus.cmp_pattern, 0);
        check("rst_clear", bus.cmp_clear, 0);
        n_rst = 1'b1;
        repeat (2) tick;

        vt[0] = mk("contig", 32'hC0A80001, 32'h11111111, 32'h22222222,
                   32'hC0A80001, 32'hC0A80001, 32'h33333333,
                   32'h44444444, -1, 1'b1, 1'b0);
        vt[1] = mk("split", 32'hC0A80001, 0, 0, 32'h0000C0A8,
                   32'h0001BEEF, 0, 0, -1, 1'b1, 1'b0);
        vt[2] = mk("bubble", 32'hC0A80001, 32'h11111111, 32'h22222222,
                   32'hC0A80001, 32'hC0A80001, 32'h33333333,
                   32'h44444444, 3, 1'b0, 1'b1);
        vt[3] = mk("word0", 32'hC0A80001, 32'hC0A80001, 0, 0, 0, 0, 0,
                   -1, 1'b0, 1'b0);
        vt[4] = mk("zero_pat", 0, 0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0);
        vt[5] = mk("last_win", 32'hDEADBEEF, 0, 0, 0, 0, 0,
                   32'hDEADBEEF, -1, 1'b1, 1'b0);
        vt[6] = mk("word1", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0,
                   -1, 1'b0, 1'b0);
        vt[7] = mk("edge_split", 32'hA1B2C3D4, 0, 32'h0000A1B2,
                   32'hC3D40000, 0, 0, 0, -1, 1'b0, 1'b0);
        vt[8] = mk("bub_eof", 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0,
                   0, 5, 1'b0, 1'b1);

        for (int t = 0; t < 9; t++) begin
            fn = 6;
            for (int j = 0; j < 6; j++) fw[j] = vt[t].w[j];
            run_frame(vt[t].nm, vt[t].pat, vt[t].bub, 0,
                      {vt[t].em, vt[t].ee});
        end

        // sof during REPORT is dropped; the held result stays stable
        cfg(32'hC0A80001);
        fn = 6;
        for (int j = 0; j < 6; j++) fw[j] = vt[0].w[j];
        send_frame(-1, -1, 0, 1'b1, t0);
        wait_result("drop_a", t0, lat);
        fn = 3;
        for (int j = 0; j < 3; j++) fw[j] = 32'hC0A80001;
        send_frame(-1, -1, 0, 1'b0, t0);
        for (int i = 0; i < 10; i++) begin
            check("drop_hold",
                  {bus.result_valid, bus.result_match, bus.result_err},
                  3'b110);
            tick;
        end
        check("drop_count", bus.drop_count, 1);
        take_result();
        fn = 6;
        for (int j = 0; j < 6; j++) fw[j] = vt[0].w[j];
        send_frame(-1, -1, 0, 1'b1, t0);
        check("drop_next_busy", bus.busy, 1);
        wait_result("drop_next", t0, lat);
        check("drop_next_match", bus.result_match, 1);
        check("drop_count_kept", bus.drop_count, 1);
        take_result();

        // pattern updates: mid-frame write deferred, same-cycle used
        cfg(32'h12345678);
        for (int j = 0; j < 6; j++) fw[j] = 0;
        fw[2] = 32'h12345678;
        send_frame(-1, 3, 32'h9ABCDEF0, 1'b1, t0);
        check("cfg_mid_pat", bus.cmp_pattern, 32'h12345678);
        wait_result("cfg_mid", t0, lat);
        check("cfg_mid_match", bus.result_match, 1);
        take_result();
        for (int j = 0; j < 6; j++) fw[j] = 0;
        fw[3] = 32'h9ABCDEF0;
        send_frame(-1, -1, 0, 1'b1, t0);
        check("cfg_new_pat", bus.cmp_pattern, 32'h9ABCDEF0);
        wait_result("cfg_new", t0, lat);
        check("cfg_new_match", bus.result_match, 1);
        take_result();
        for (int j = 0; j < 6; j++) fw[j] = 0;
        fw[2] = 32'h12345678;
        send_frame(-1, -1, 0, 1'b1, t0);
        wait_result("cfg_old", t0, lat);
        check("cfg_old_match", bus.result_match, 0);
        take_result();
        for (int j = 0; j < 6; j++) fw[j] = 0;
        fw[4] = 32'h0BADF00D;
        send_frame(-1, 0, 32'h0BADF00D, 1'b1, t0);
        wait_result("cfg_same", t0, lat);
        check("cfg_same_match", bus.result_match, 1);
        take_result();

        // single-word frame and sof inside a frame
        fn = 1;
        fw[0] = 32'h0BADF00D;
        send_frame(-1, -1, 0, 1'b1, t0);
        wait_result("one", t0, lat);
        check("one_lat", lat, 1 + DC);
        check("one_match", bus.result_match, 0);
        check("one_err", bus.result_err, 0);
        take_result();
        fn = 6;
        for (int j = 0; j < 6; j++) fw[j] = 0;
        fw[3] = 32'h0BADF00D;
        xsof = 3;
        send_frame(-1, -1, 0, 1'b1, t0);
        xsof = -1;
        wait_result("xsof", t0, lat);
        check("xsof_match", bus.result_match, 0);
        check("xsof_err", bus.result_err, 1);
        check("xsof_drop", bus.drop_count, 1);
        take_result();

        for (int r = 0; r < 40; r++) begin
            pat = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            n = $urandom_range(1, 9);
            fn = n;
            for (int j = 0; j < n; j++)
                fw[j] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) != 0 && n >= 1) begin
                p = $urandom_range(0, 4 * n - 4);
                for (int j = 0; j < 4; j++)
                    fw[(p + j) / 4][31 - 8 * ((p + j) % 4) -: 8] =
                        pat[31 - 8 * j -: 8];
            end
            bub = (n >= 2 && $urandom_range(0, 3) == 0) ?
                  $urandom_range(1, n - 1) : -1;
            mode = $urandom_range(0, 1);
            run_frame("rnd", pat, bub, mode, model(pat, n, bub));
            repeat ($urandom_range(0, 2)) tick;
        end

        // asynchronous reset in the middle of a frame
        cfg(32'hC0A80001);
        bus.data_valid = 1'b1; bus.sof = 1'b1;
        bus.data_in = 32'hC0A80001;
        tick;
        bus.sof = 1'b0;
        tick;
        tick;
        check("pre_rst_busy", bus.busy, 1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rv", bus.result_valid, 0);
        check("mid_rst_cdata", bus.cmp_data, 0);
        check("mid_rst_cpat", bus.cmp_pattern, 0);
        check("mid_rst_drop", bus.drop_count, 0);
        tick;
        idle_inputs();
        tick;
        n_rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (bus.result_valid === 1'b1) seen = 1'b1;
        end
        check("rst_no_result", seen, 0);
        check("rst_idle_busy", bus.busy, 0);
        fn = 6;
        for (int j = 0; j < 6; j++) fw[j] = vt[0].w[j];
        run_frame("post_rst", 32'hC0A80001, -1, 0, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
